// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/done handshake.
// Optional macro MULDIV_EARLY_OUT_EN finishes trivial divides/multiplies straight from IDLE.
module muldiv_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_neg;
  logic             r_bzero;
  logic [XLEN-1:0]  r_b;
  logic [PW-1:0]    r_acc;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  logic             w_accept;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_neg_res;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic [XLEN:0]    w_msum;
  logic [PW-1:0]    w_mul_next;
  logic [XLEN:0]    w_dshift;
  logic [XLEN:0]    w_ddiff;
  logic             w_dge;
  logic [PW-1:0]    w_div_next;
  logic [PW-1:0]    w_prod_fix;
  logic [XLEN-1:0]  w_quo_fix;
  logic [XLEN-1:0]  w_rem_fix;
  logic [XLEN-1:0]  w_fix_res;
  logic             w_early;
  logic [XLEN-1:0]  w_early_res;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // Operand decode: signedness per op, magnitudes and the sign the final result must carry.
  assign w_accept  = start && !kill;
  assign w_sgn_a   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sgn_b   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_neg_a   = w_sgn_a && rs1[XLEN-1];
  assign w_neg_b   = w_sgn_b && rs2[XLEN-1];
  assign w_mag_a   = w_neg_a ? (~rs1 + XLEN'(1)) : rs1;
  assign w_mag_b   = w_neg_b ? (~rs2 + XLEN'(1)) : rs2;
  assign w_neg_res = (funct3[2] && funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  // Multiply step: r_acc = {partial product, remaining multiplier bits}, r_b = multiplicand.
  assign w_msum     = {1'b0, r_acc[PW-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_msum, r_acc[XLEN-1:1]};

  // Divide step: r_acc = {partial remainder, dividend/quotient}; borrow bit decides the quotient bit.
  assign w_dshift   = {r_acc[PW-1:XLEN], r_acc[XLEN-1]};
  assign w_ddiff    = w_dshift - {1'b0, r_b};
  assign w_dge      = !w_ddiff[XLEN];
  assign w_div_next = {(w_dge ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_dge};

  assign w_prod_fix = r_neg ? (~r_acc + PW'(1)) : r_acc;
  assign w_quo_fix  = r_neg ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg ? (~r_acc[PW-1:XLEN] + XLEN'(1)) : r_acc[PW-1:XLEN];

  // Divide by zero keeps the natural remainder (== rs1) but forces the quotient to all ones.
  always_comb begin
    w_fix_res = w_prod_fix[XLEN-1:0];
    case (r_op)
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[PW-1:XLEN];
      3'b100, 3'b101:         w_fix_res = r_bzero ? '1 : w_quo_fix;
      3'b110, 3'b111:         w_fix_res = w_rem_fix;
      default:                w_fix_res = w_prod_fix[XLEN-1:0];
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    w_early     = 1'b0;
    w_early_res = '0;
    if (funct3[2]) begin
      if (rs2 == '0) begin
        w_early     = 1'b1;
        w_early_res = funct3[1] ? rs1 : '1;
      end else if (!funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)) begin
        w_early     = 1'b1;
        w_early_res = funct3[1] ? '0 : rs1;
      end
    end else if ((rs1 == '0) || (rs2 == '0)) begin
      w_early = 1'b1;
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_early ? S_DONE : S_CALC;
      S_CALC: begin
        if (kill)                               w_next_state = S_IDLE;
        else if (r_cnt == CNT_W'(XLEN - 1))     w_next_state = S_FIX;
      end
      S_FIX:   w_next_state = kill ? S_IDLE : S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_bzero  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= funct3;
            r_neg   <= w_neg_res;
            r_bzero <= (rs2 == '0);
            r_cnt   <= '0;
            r_b     <= funct3[2] ? w_mag_b : w_mag_a;
            r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
            if (w_early) r_result <= w_early_res;
          end
        end
        S_CALC: begin
          if (!kill) begin
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!kill) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: arithmetic reference model, per-cycle output checker, directed vectors.
module tb_muldiv_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_res;
  logic [31:0] last_res;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  muldiv_iter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M results from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      ub;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb);            return p[63:32]; end
      3'd2: begin p = 64'(sa * ub);            return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin if (b == 32'h0) return 32'hFFFF_FFFF; return 32'(sa / sb); end
      3'd5: begin if (b == 32'h0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 32'h0) return a; return 32'(sa % sb); end
      default: begin if (b == 32'h0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit model_early(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    bit trivial;
    if (f[2]) trivial = (b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      trivial = (a == 32'h0) || (b == 32'h0);
    return EARLY && trivial;
  endfunction

  // Compare process: every done must match the model, result must hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_res = result;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else                   check("result_vs_model", result, exp_q.pop_front());
      end else begin
        check("result_hold", result, prev_res);
      end
      prev_res = result;
    end
  end

  // Called at a negedge; accepts at the next edge, returns at the negedge of the following IDLE cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input bit hold);
    int k;
    int busy_low;
    bit got;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(f, a, b));
    if (!hold) start = 1'b0;
    funct3 = ~f; rs1 = ~a; rs2 = ~b;
    k = 0; busy_low = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (!busy) busy_low++;
      if (done)  got = 1'b1;
    end
    start = 1'b0;
    check("done_latency", 32'(k), model_early(f, a, b) ? 32'd1 : 32'd34);
    check("busy_while_active", 32'(busy_low), 32'd0);
    if (got) check("result_literal", result, lit);
    else     exp_q.delete();
    last_res = lit;
    @(negedge clk);
    check("idle_after_done", {30'h0, busy, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; rs1 = 32'h0; rs2 = 32'h0; last_res = 32'h0;
    @(negedge clk);
    check("reset_state", {30'h0, busy, done}, 32'd0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-op vectors with hand-computed results; first one holds start high throughout.
    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    repeat (3) @(negedge clk);
    check("held_start_no_second_op", {30'h0, busy, done}, 32'd0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd100,       32'd7,         32'd14,        1'b0);
    run_op(3'd7, 32'd100,       32'd7,         32'd2,         1'b0);
    run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd5,         32'd0,         32'd5,         1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);

    // Kill a DIV in mid-CALC: back to idle, no done, result untouched.
    funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_result", result, last_res);
    repeat (3) @(negedge clk);
    check("kill_no_done", 32'(done), 32'd0);
    run_op(3'd4, 32'd1000, 32'd3, 32'd333, 1'b0);

    // kill together with start in IDLE drops the request.
    funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd4; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start_dropped", 32'(busy), 32'd0);
    @(negedge clk);
    check("kill_start_still_idle", {30'h0, busy, done}, 32'd0);

    run_op(3'd0, 32'd0,         32'h0001_2345, 32'h0,         1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0);
    run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1,         1'b0);
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0);
    run_op(3'd5, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 1'b0);

    // Asynchronous reset between edges in mid-CALC.
    funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_flags", {30'h0, busy, done}, 32'd0);
    check("async_reset_result", result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd7, 32'h8000_0000, 32'd3, 32'd2, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
